fpu_class_pipe: RTL and testbench

Multi-lane, pipelined floating-point classifier for the FPU. It accepts one vector of NUM_LANES operands per handshake and returns either the RISC-V FCLASS mask or the raw per-lane class record for each operand. An OR of all exception flags is accumulated into a sticky register that the CSR path reads and clears. It sits beside the other FPU cores behind the FPU dispatch, with the same valid/ready and tag conventions.

---
 rtl/fpu_class_pipe.sv | 175 +++++++++++++++++
 tb/tb_fpu_class_pipe.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fpu_class_pipe.sv
// fpu_class_pipe: multi-lane pipelined floating-point classifier.
// Each accepted vector returns either the FCLASS one-hot mask or the raw
// class record per lane, LATENCY cycles later. A sticky OR of the returned
// exception flags is kept for the CSR path.
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   valid_in / ready_in        request handshake (ready_in is combinational)
//   op_mode                    0 = FCLASS mask, 1 = raw class record
//   tag_in / tag_out           opaque tag carried alongside the result
//   lane_mask_in               active lanes; inactive lanes return 0
//   dataa                      NUM_LANES operands, lane i at [i*FLEN +: FLEN]
//   valid_out / ready_out      result handshake
//   result                     NUM_LANES x 32-bit lane results
//   fflags_out                 {NV,DZ,OF,UF,NX} for the current result
//   fflags_clr / fflags_sticky sticky flag clear and accumulated flags
module fpu_class_pipe #(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned EXP_BITS  = 8,
  parameter int unsigned MAN_BITS  = 23,
  parameter int unsigned TAGW      = 8,
  parameter int unsigned LATENCY   = 2,
  localparam int unsigned FLEN     = 1 + EXP_BITS + MAN_BITS,
  localparam int unsigned RW       = NUM_LANES * 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      valid_in,
  output logic                      ready_in,
  input  logic                      op_mode,
  input  logic [TAGW-1:0]           tag_in,
  input  logic [NUM_LANES-1:0]      lane_mask_in,
  input  logic [NUM_LANES*FLEN-1:0] dataa,
  output logic                      valid_out,
  input  logic                      ready_out,
  output logic [TAGW-1:0]           tag_out,
  output logic [RW-1:0]             result,
  output logic [4:0]                fflags_out,
  input  logic                      fflags_clr,
  output logic [4:0]                fflags_sticky
);

  logic [RW-1:0]        res_all_c;
  logic [NUM_LANES-1:0] nv_all_c;
  logic                 stall_c;
  logic                 hs_c;

  // Per-lane classification, computed on the incoming operands.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [FLEN-1:0]     opnd;
    logic                sgn;
    logic [EXP_BITS-1:0] exp_f;
    logic [MAN_BITS-1:0] man_f;
    logic                e_ones, e_zero, m_zero;
    logic                is_inf, is_nan, is_qnan, is_snan;
    logic                is_zero, is_sub, is_norm;
    logic [31:0]         res_c;
    logic                nv_c;

    assign opnd    = dataa[i*FLEN +: FLEN];
    assign sgn     = opnd[FLEN-1];
    assign exp_f   = opnd[FLEN-2 -: EXP_BITS];
    assign man_f   = opnd[MAN_BITS-1:0];
    assign e_ones  = &exp_f;
    assign e_zero  = ~|exp_f;
    assign m_zero  = ~|man_f;
    assign is_inf  = e_ones & m_zero;
    assign is_nan  = e_ones & ~m_zero;
    assign is_qnan = is_nan & man_f[MAN_BITS-1];
    assign is_snan = is_nan & ~man_f[MAN_BITS-1];
    assign is_zero = e_zero & m_zero;
    assign is_sub  = e_zero & ~m_zero;
    assign is_norm = ~e_ones & ~e_zero;

    // Lane result encoding; NaN classes ignore the sign.
    always_comb begin
      res_c = '0;
      nv_c  = 1'b0;
      if (lane_mask_in[i]) begin
        if (op_mode) begin
          res_c[6:0] = {is_norm, is_zero, is_sub, is_inf, is_nan, is_qnan, is_snan};
          nv_c       = is_snan;
        end else begin
          res_c[0] = is_inf  &  sgn;
          res_c[1] = is_norm &  sgn;
          res_c[2] = is_sub  &  sgn;
          res_c[3] = is_zero &  sgn;
          res_c[4] = is_zero & ~sgn;
          res_c[5] = is_sub  & ~sgn;
          res_c[6] = is_norm & ~sgn;
          res_c[7] = is_inf  & ~sgn;
          res_c[8] = is_snan;
          res_c[9] = is_qnan;
        end
      end
    end

    assign res_all_c[i*32 +: 32] = res_c;
    assign nv_all_c[i]           = nv_c;
  end

  logic            valid_q [LATENCY];
  logic            valid_d [LATENCY];
  logic [TAGW-1:0] tag_q   [LATENCY];
  logic [TAGW-1:0] tag_d   [LATENCY];
  logic [RW-1:0]   res_q   [LATENCY];
  logic [RW-1:0]   res_d   [LATENCY];
  logic [4:0]      flags_q [LATENCY];
  logic [4:0]      flags_d [LATENCY];
  logic [4:0]      sticky_q;
  logic [4:0]      sticky_d;

  assign stall_c = valid_q[LATENCY-1] & ~ready_out;
  assign hs_c    = valid_q[LATENCY-1] & ready_out;
  assign ready_in = ~stall_c;

  // Pipeline advance: whole pipe holds on a stall, bubbles travel as-is.
  always_comb begin
    for (int k = 0; k < LATENCY; k++) begin
      valid_d[k] = valid_q[k];
      tag_d[k]   = tag_q[k];
      res_d[k]   = res_q[k];
      flags_d[k] = flags_q[k];
    end
    if (!stall_c) begin
      valid_d[0] = valid_in;
      tag_d[0]   = valid_in ? tag_in : '0;
      res_d[0]   = valid_in ? res_all_c : '0;
      flags_d[0] = valid_in ? {|nv_all_c, 4'b0000} : 5'b00000;
      for (int k = 1; k < LATENCY; k++) begin
        valid_d[k] = valid_q[k-1];
        tag_d[k]   = tag_q[k-1];
        res_d[k]   = res_q[k-1];
        flags_d[k] = flags_q[k-1];
      end
    end
  end

  // Sticky flags: a clear in a handshake cycle drops old flags, keeps new ones.
  always_comb begin
    sticky_d = sticky_q;
    if (hs_c) begin
      sticky_d = fflags_clr ? flags_q[LATENCY-1] : (sticky_q | flags_q[LATENCY-1]);
    end else if (fflags_clr) begin
      sticky_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < LATENCY; k++) begin
        valid_q[k] <= 1'b0;
        tag_q[k]   <= '0;
        res_q[k]   <= '0;
        flags_q[k] <= '0;
      end
      sticky_q <= '0;
    end else begin
      for (int k = 0; k < LATENCY; k++) begin
        valid_q[k] <= valid_d[k];
        tag_q[k]   <= tag_d[k];
        res_q[k]   <= res_d[k];
        flags_q[k] <= flags_d[k];
      end
      sticky_q <= sticky_d;
    end
  end

  assign valid_out     = valid_q[LATENCY-1];
  assign tag_out       = tag_q[LATENCY-1];
  assign result        = res_q[LATENCY-1];
  assign fflags_out    = flags_q[LATENCY-1];
  assign fflags_sticky = sticky_q;

endmodule

// File: tb/tb_fpu_class_pipe.sv
// Directed bench for fpu_class_pipe in the FP32, 4-lane, 2-stage configuration.
module tb_fpu_class_pipe;

  logic         clk = 1'b0;
  logic         reset;
  logic         valid_in;
  logic         ready_in;
  logic         op_mode;
  logic [7:0]   tag_in;
  logic [3:0]   lane_mask_in;
  logic [127:0] dataa;
  logic         valid_out;
  logic         ready_out;
  logic [7:0]   tag_out;
  logic [127:0] result;
  logic [4:0]   fflags_out;
  logic         fflags_clr;
  logic [4:0]   fflags_sticky;

  int n_tests = 0;
  int n_fail  = 0;

  fpu_class_pipe #(
    .NUM_LANES(4), .EXP_BITS(8), .MAN_BITS(23), .TAGW(8), .LATENCY(2)
  ) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
    .op_mode(op_mode), .tag_in(tag_in), .lane_mask_in(lane_mask_in), .dataa(dataa),
    .valid_out(valid_out), .ready_out(ready_out), .tag_out(tag_out), .result(result),
    .fflags_out(fflags_out), .fflags_clr(fflags_clr), .fflags_sticky(fflags_sticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One transaction with ready_out=1; called just after a rising edge.
  task automatic run1(input string nm, input logic op, input logic [7:0] tg,
                      input logic [3:0] mk, input logic [127:0] d,
                      input logic [127:0] er, input logic [4:0] ef,
                      input logic clr, input logic [4:0] es);
    valid_in = 1'b1; op_mode = op; tag_in = tg; lane_mask_in = mk; dataa = d;
    ready_out = 1'b1;
    @(negedge clk);
    check({nm, ":ready_in"}, 128'(ready_in), 128'(1));
    @(posedge clk); #1;
    valid_in = 1'b0;
    @(negedge clk);
    check({nm, ":early"}, 128'(valid_out), 128'(0));
    @(posedge clk);
    @(negedge clk);
    check({nm, ":valid"}, 128'(valid_out), 128'(1));
    check({nm, ":result"}, result, er);
    check({nm, ":tag"}, 128'(tag_out), 128'(tg));
    check({nm, ":fflags"}, 128'(fflags_out), 128'(ef));
    fflags_clr = clr;
    @(posedge clk); #1;
    fflags_clr = 1'b0;
    @(negedge clk);
    check({nm, ":sticky"}, 128'(fflags_sticky), 128'(es));
    check({nm, ":drained"}, 128'(valid_out), 128'(0));
    @(posedge clk); #1;
  endtask

  localparam logic [127:0] FC1_D = {32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h7F800001};
  localparam logic [127:0] FC1_R = {32'h080, 32'h001, 32'h200, 32'h100};
  localparam logic [127:0] FC2_D = {32'h80000000, 32'h00000001, 32'h3F800000, 32'h80000001};
  localparam logic [127:0] FC2_R = {32'h008, 32'h020, 32'h040, 32'h004};
  // Lanes 1 and 3 hold sNaNs but stay masked off, so they must not raise NV.
  localparam logic [127:0] RAW_D = {32'h7F800001, 32'h7F800001, 32'h7F800001, 32'h3F800000};
  localparam logic [127:0] RAW_R = {32'h0, 32'h05, 32'h0, 32'h40};
  localparam logic [127:0] RAWM_R = {32'h0, 32'h0, 32'h0, 32'h40};

  logic [31:0] bp_val [6] = '{32'h7F800000, 32'hFF800000, 32'h00000000,
                              32'h80000000, 32'h3F800000, 32'h7FC00000};
  logic [31:0] bp_cls [6] = '{32'h080, 32'h001, 32'h010, 32'h008, 32'h040, 32'h200};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int sent, rcv, stale;
    logic stalled_prev, acc;
    logic [7:0] held_tag;
    logic [127:0] held_res;

    reset = 1'b1; valid_in = 1'b0; op_mode = 1'b0; tag_in = '0; lane_mask_in = '0;
    dataa = '0; ready_out = 1'b1; fflags_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst:valid_out", 128'(valid_out), 128'(0));
    check("rst:ready_in", 128'(ready_in), 128'(1));
    check("rst:sticky", 128'(fflags_sticky), 128'(0));
    check("rst:result", result, 128'(0));
    @(posedge clk); #1;

    run1("fclass1", 1'b0, 8'h11, 4'hF, FC1_D, FC1_R, 5'h00, 1'b0, 5'h00);
    run1("fclass2", 1'b0, 8'h22, 4'hF, FC2_D, FC2_R, 5'h00, 1'b0, 5'h00);
    run1("raw",     1'b1, 8'h33, 4'b0101, RAW_D, RAW_R, 5'h10, 1'b0, 5'h10);
    run1("raw_msk", 1'b1, 8'h44, 4'b0001, RAW_D, RAWM_R, 5'h00, 1'b0, 5'h10);
    run1("raw2",    1'b1, 8'h55, 4'b0101, RAW_D, RAW_R, 5'h10, 1'b0, 5'h10);

    // Clear with no handshake.
    fflags_clr = 1'b1;
    @(posedge clk); #1;
    fflags_clr = 1'b0;
    @(negedge clk);
    check("clr_alone:sticky", 128'(fflags_sticky), 128'(0));
    @(posedge clk); #1;

    // Clear together with a handshake: old flags go, new flags stay.
    run1("clr_nv", 1'b1, 8'h66, 4'b0101, RAW_D, RAW_R, 5'h10, 1'b1, 5'h10);
    run1("clr_fc", 1'b0, 8'h77, 4'hF, FC1_D, FC1_R, 5'h00, 1'b1, 5'h00);

    // Back-pressure stream of six requests with a 3-cycle stall.
    sent = 0; rcv = 0; stalled_prev = 1'b0; held_tag = '0; held_res = '0;
    for (int c = 0; c < 30; c++) begin
      ready_out = !(c >= 3 && c <= 5);
      if (sent < 6) begin
        valid_in = 1'b1; op_mode = 1'b0; lane_mask_in = 4'hF;
        tag_in = 8'(sent + 1); dataa = {4{bp_val[sent]}};
      end else begin
        valid_in = 1'b0;
      end
      @(negedge clk);
      if (stalled_prev) begin
        check("bp:hold_valid", 128'(valid_out), 128'(1));
        check("bp:hold_tag", 128'(tag_out), 128'(held_tag));
        check("bp:hold_res", result, held_res);
      end
      if (valid_out && !ready_out) begin
        check("bp:ready_in", 128'(ready_in), 128'(0));
        stalled_prev = 1'b1; held_tag = tag_out; held_res = result;
      end else begin
        stalled_prev = 1'b0;
      end
      if (valid_out && ready_out) begin
        if (rcv < 6) begin
          check("bp:tag", 128'(tag_out), 128'(rcv + 1));
          check("bp:result", result, {4{bp_cls[rcv]}});
        end else begin
          check("bp:extra", 128'(valid_out), 128'(0));
        end
        rcv++;
      end
      acc = valid_in && ready_in;
      @(posedge clk); #1;
      if (acc) sent++;
    end
    valid_in = 1'b0; ready_out = 1'b1;
    check("bp:sent", 128'(sent), 128'(6));
    check("bp:received", 128'(rcv), 128'(6));

    // Reset with two transactions in flight.
    run1("pre_rst", 1'b1, 8'h88, 4'b0101, RAW_D, RAW_R, 5'h10, 1'b0, 5'h10);
    valid_in = 1'b1; op_mode = 1'b1; tag_in = 8'hA1; lane_mask_in = 4'b0101;
    dataa = RAW_D; ready_out = 1'b0;
    @(posedge clk); #1;
    tag_in = 8'hA2;
    @(posedge clk); #1;
    valid_in = 1'b0; reset = 1'b1;
    @(negedge clk);
    check("inflight:valid_out", 128'(valid_out), 128'(1));
    @(posedge clk); #1;
    reset = 1'b0; ready_out = 1'b1;
    @(negedge clk);
    check("mid_rst:valid_out", 128'(valid_out), 128'(0));
    check("mid_rst:sticky", 128'(fflags_sticky), 128'(0));
    check("mid_rst:ready_in", 128'(ready_in), 128'(1));
    check("mid_rst:tag", 128'(tag_out), 128'(0));
    stale = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (valid_out) stale++;
    end
    check("mid_rst:stale", 128'(stale), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
